monkey_collision_detector: RTL and testbench

//  Per-frame collision classifier feeding monkey_moveCollision. Watches the pixel-scan

---
 rtl/monkey_collision_detector.sv | 104 ++++++++++
 tb/tb_monkey_collision_detector.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/monkey_collision_detector.sv
// Per-frame collision classifier: accumulates monkey/ledge/rope/enemy overlaps during a frame
// and publishes stable flags at each startOfFrame, plus a one-clock new-enemy-hit pulse.
module monkey_collision_detector #(
  parameter int OBJECT_WIDTH    = 64,
  parameter int OBJECT_HEIGHT   = 64,
  parameter int EDGE_MARGIN     = 4,
  parameter int ROPE_MIN_PIXELS = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        monkeyDR,
  input  logic        ledgeDR,
  input  logic        ropeDR,
  input  logic        enemyDR,
  input  logic [10:0] offsetX,
  input  logic [10:0] offsetY,
  output logic        collision,
  output logic        onRope,
  output logic        objectHit,
  output logic [3:0]  HitEdgeCode,
  output logic        hitPulse
);

  localparam logic [10:0] WIDTH    = 11'(OBJECT_WIDTH);
  localparam logic [10:0] HEIGHT   = 11'(OBJECT_HEIGHT);
  localparam logic [10:0] MARGIN   = 11'(EDGE_MARGIN);
  localparam logic [7:0]  ROPE_MIN = 8'(ROPE_MIN_PIXELS);

  typedef struct packed {
    logic        sof;
    logic        monkey;
    logic        ledge;
    logic        rope;
    logic        enemy;
    logic [10:0] x;
    logic [10:0] y;
  } pixel_t;

  pixel_t      s1;
  logic        acc_ledge;
  logic        acc_enemy;
  logic [3:0]  acc_edge;
  logic [7:0]  rope_cnt;

  logic        ledge_px;
  logic        enemy_px;
  logic        rope_px;
  logic [3:0]  edge_px;
  logic [7:0]  rope_inc;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    ledge_px = s1.monkey & s1.ledge;
    enemy_px = s1.monkey & s1.enemy;
    rope_px  = s1.monkey & s1.rope;
    edge_px  = 4'b0000;
    if (ledge_px) begin
      edge_px[0] = (s1.y < MARGIN);
      edge_px[1] = (s1.x >= WIDTH - MARGIN) && (s1.x < WIDTH);
      edge_px[2] = (s1.y >= HEIGHT - MARGIN) && (s1.y < HEIGHT);
      edge_px[3] = (s1.x < MARGIN);
    end
    rope_inc = (rope_cnt == 8'hFF) ? rope_cnt : rope_cnt + 8'd1;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      s1          <= '0;
      acc_ledge   <= 1'b0;
      acc_enemy   <= 1'b0;
      acc_edge    <= 4'b0000;
      rope_cnt    <= 8'd0;
      collision   <= 1'b0;
      onRope      <= 1'b0;
      objectHit   <= 1'b0;
      HitEdgeCode <= 4'b0000;
      hitPulse    <= 1'b0;
    end else begin
      s1 <= '{sof: startOfFrame, monkey: monkeyDR, ledge: ledgeDR, rope: ropeDR,
              enemy: enemyDR, x: offsetX, y: offsetY};
      if (s1.sof) begin
        collision   <= acc_ledge | acc_enemy;
        objectHit   <= acc_enemy;
        HitEdgeCode <= acc_edge;
        onRope      <= (rope_cnt >= ROPE_MIN);
        hitPulse    <= acc_enemy & ~objectHit;
        // The pixel sampled alongside startOfFrame opens the new frame.
        acc_ledge   <= ledge_px;
        acc_enemy   <= enemy_px;
        acc_edge    <= edge_px;
        rope_cnt    <= {7'd0, rope_px};
      end else begin
        hitPulse    <= 1'b0;
        acc_ledge   <= acc_ledge | ledge_px;
        acc_enemy   <= acc_enemy | enemy_px;
        acc_edge    <= acc_edge | edge_px;
        if (rope_px) rope_cnt <= rope_inc;
      end
    end
  end

endmodule

// File: tb/tb_monkey_collision_detector.sv
// Self-checking bench for monkey_collision_detector: edge-zone table, directed frame
// sequences and randomized frames against a frame-level reference model.
module tb_monkey_collision_detector;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame, monkeyDR, ledgeDR, ropeDR, enemyDR;
  logic [10:0] offsetX, offsetY;
  logic        collision, onRope, objectHit, hitPulse;
  logic [3:0]  HitEdgeCode;

  monkey_collision_detector dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .monkeyDR(monkeyDR),
    .ledgeDR(ledgeDR), .ropeDR(ropeDR), .enemyDR(enemyDR), .offsetX(offsetX),
    .offsetY(offsetY), .collision(collision), .onRope(onRope), .objectHit(objectHit),
    .HitEdgeCode(HitEdgeCode), .hitPulse(hitPulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit m, l, r, e;
    logic [10:0] x, y;
  } pix_t;

  typedef struct {
    logic [10:0] x, y;
    bit          m;
    bit [3:0]    edges;
    bit          coll;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model: what has been seen in the current frame, counted plainly.
  bit       f_ledge, f_enemy;
  bit [3:0] f_edges;
  int       f_rope;
  bit       last_obj;
  bit       e_coll, e_rope, e_obj, e_pulse;
  bit [3:0] e_edge;

  pix_t idle = '{0, 0, 0, 0, 11'd0, 11'd0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    f_ledge = 0; f_enemy = 0; f_edges = 4'b0000; f_rope = 0;
  endfunction

  function automatic void model_add(input pix_t p);
    int x, y;
    x = int'(p.x); y = int'(p.y);
    if (!p.m) return;
    if (p.l) begin
      f_ledge = 1;
      if (y < 4)            f_edges[0] = 1;
      if (x >= 60 && x < 64) f_edges[1] = 1;
      if (y >= 60 && y < 64) f_edges[2] = 1;
      if (x < 4)            f_edges[3] = 1;
    end
    if (p.e) f_enemy = 1;
    if (p.r) f_rope++;
  endfunction

  function automatic void model_publish();
    e_coll  = f_ledge | f_enemy;
    e_obj   = f_enemy;
    e_edge  = f_edges;
    e_rope  = (f_rope >= 8);
    e_pulse = f_enemy & ~last_obj;
    last_obj = f_enemy;
    model_clear();
  endfunction

  task automatic apply(input pix_t p, input bit sof);
    @(negedge clk);
    startOfFrame = sof;
    monkeyDR = p.m; ledgeDR = p.l; ropeDR = p.r; enemyDR = p.e;
    offsetX = p.x; offsetY = p.y;
    if (sof) model_publish();
    model_add(p);
  endtask

  // Pulse startOfFrame (with pixel p in that same cycle), then check the published frame.
  task automatic boundary(input pix_t p, input string tag);
    apply(p, 1'b1);
    apply(idle, 1'b0);
    @(negedge clk);
    check({tag, ".collision"}, 32'(collision), 32'(e_coll));
    check({tag, ".onRope"}, 32'(onRope), 32'(e_rope));
    check({tag, ".objectHit"}, 32'(objectHit), 32'(e_obj));
    check({tag, ".edge"}, 32'(HitEdgeCode), 32'(e_edge));
    check({tag, ".hitPulse"}, 32'(hitPulse), 32'(e_pulse));
    @(negedge clk);
    check({tag, ".pulse_clear"}, 32'(hitPulse), 32'd0);
    check({tag, ".coll_hold"}, 32'(collision), 32'(e_coll));
  endtask

  task automatic pixels(input pix_t p, input int n);
    for (int i = 0; i < n; i++) apply(p, 1'b0);
  endtask

  initial begin
    vec_t tbl[$];
    pix_t p;

    tbl.push_back('{11'd30,  11'd62,   1'b1, 4'b0100, 1'b1});
    tbl.push_back('{11'd0,   11'd0,    1'b1, 4'b1001, 1'b1});
    tbl.push_back('{11'd63,  11'd63,   1'b1, 4'b0110, 1'b1});
    tbl.push_back('{11'd63,  11'd0,    1'b1, 4'b0011, 1'b1});
    tbl.push_back('{11'd0,   11'd63,   1'b1, 4'b1100, 1'b1});
    tbl.push_back('{11'd30,  11'd30,   1'b1, 4'b0000, 1'b1});
    tbl.push_back('{11'd4,   11'd4,    1'b1, 4'b0000, 1'b1});
    tbl.push_back('{11'd3,   11'd3,    1'b1, 4'b1001, 1'b1});
    tbl.push_back('{11'd60,  11'd59,   1'b1, 4'b0010, 1'b1});
    tbl.push_back('{11'd59,  11'd60,   1'b1, 4'b0100, 1'b1});
    tbl.push_back('{11'd100, 11'd30,   1'b1, 4'b0000, 1'b1});
    tbl.push_back('{11'd30,  11'd2000, 1'b1, 4'b0000, 1'b1});
    tbl.push_back('{11'd64,  11'd2,    1'b1, 4'b0001, 1'b1});
    tbl.push_back('{11'd0,   11'd0,    1'b0, 4'b0000, 1'b0});

    resetN = 1'b0;
    startOfFrame = 0; monkeyDR = 0; ledgeDR = 0; ropeDR = 0; enemyDR = 0;
    offsetX = '0; offsetY = '0;
    model_clear(); last_obj = 0;
    repeat (3) @(negedge clk);
    check("reset.collision", 32'(collision), 32'd0);
    check("reset.onRope", 32'(onRope), 32'd0);
    check("reset.objectHit", 32'(objectHit), 32'd0);
    check("reset.edge", 32'(HitEdgeCode), 32'd0);
    check("reset.hitPulse", 32'(hitPulse), 32'd0);
    resetN = 1'b1;

    // Edge-zone table: one ledge pixel per frame.
    foreach (tbl[i]) begin
      p = '{tbl[i].m, 1'b1, 1'b0, 1'b0, tbl[i].x, tbl[i].y};
      apply(p, 1'b0);
      boundary(idle, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d.edge_const", i), 32'(HitEdgeCode), 32'(tbl[i].edges));
      check($sformatf("tbl%0d.coll_const", i), 32'(collision), 32'(tbl[i].coll));
    end

    // 20 bottom-edge ledge pixels.
    pixels('{1, 1, 0, 0, 11'd30, 11'd62}, 20);
    boundary(idle, "bottom20");
    check("bottom20.edge_const", 32'(HitEdgeCode), 32'b0100);

    // Rope threshold and saturation.
    pixels('{1, 0, 1, 0, 11'd30, 11'd30}, 7);
    boundary(idle, "rope7");
    check("rope7.const", 32'(onRope), 32'd0);
    pixels('{1, 0, 1, 0, 11'd30, 11'd30}, 8);
    boundary(idle, "rope8");
    check("rope8.const", 32'(onRope), 32'd1);
    pixels('{1, 0, 1, 0, 11'd30, 11'd30}, 300);
    boundary(idle, "rope300");
    check("rope300.const", 32'(onRope), 32'd1);
    pixels('{1, 0, 1, 0, 11'd30, 11'd30}, 260);
    boundary(idle, "rope260");
    check("rope260.const", 32'(onRope), 32'd1);
    pixels('{0, 0, 1, 0, 11'd30, 11'd30}, 20);
    boundary(idle, "rope_nomonkey");

    // Enemy in frames 2 and 3 only: pulse on frame 2 publish only.
    pixels('{1, 0, 0, 0, 11'd10, 11'd10}, 5);
    boundary(idle, "enemy_f1");
    pixels('{1, 0, 0, 1, 11'd10, 11'd10}, 5);
    boundary(idle, "enemy_f2");
    pixels('{1, 0, 0, 1, 11'd10, 11'd10}, 5);
    boundary(idle, "enemy_f3");
    check("enemy_f3.pulse_const", 32'(hitPulse), 32'd0);

    // Ledge pixel coincident with startOfFrame belongs to the next frame.
    boundary('{1, 1, 0, 0, 11'd0, 11'd0}, "sof_px_a");
    check("sof_px_a.const", 32'(collision), 32'd0);
    boundary(idle, "sof_px_b");
    check("sof_px_b.const", 32'(HitEdgeCode), 32'b1001);

    // Back-to-back startOfFrame with no pixels.
    boundary(idle, "empty");

    // Asynchronous reset mid-frame.
    pixels('{1, 1, 0, 1, 11'd0, 11'd0}, 4);
    boundary('{1, 1, 0, 1, 11'd63, 11'd63}, "pre_reset");
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    check("async_reset.collision", 32'(collision), 32'd0);
    check("async_reset.objectHit", 32'(objectHit), 32'd0);
    check("async_reset.edge", 32'(HitEdgeCode), 32'd0);
    model_clear(); last_obj = 0;
    @(negedge clk);
    resetN = 1'b1;
    pixels('{1, 0, 1, 0, 11'd5, 11'd5}, 9);
    boundary(idle, "post_reset");
    check("post_reset.coll_const", 32'(collision), 32'd0);

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(0, 30);
      for (int i = 0; i < n; i++) begin
        p.m = ($urandom_range(0, 3) != 0);
        p.l = ($urandom_range(0, 7) == 0);
        p.r = $urandom_range(0, 1);
        p.e = ($urandom_range(0, 15) == 0);
        p.x = 11'($urandom_range(0, 70));
        p.y = 11'($urandom_range(0, 70));
        apply(p, 1'b0);
      end
      p.m = $urandom_range(0, 1); p.l = $urandom_range(0, 1);
      p.r = $urandom_range(0, 1); p.e = ($urandom_range(0, 3) == 0);
      p.x = 11'($urandom_range(0, 70)); p.y = 11'($urandom_range(0, 70));
      boundary(p, $sformatf("rand%0d", f));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
